prv_trap_ctrl: RTL and testbench
================================

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 exc_in  in  12  pipeline exception flags {fault_store_page, fault_load_page, fault_insn_page, env, breakpoint, mal_s, fault_s, mal_l, fault_l, illegal_insn, mal_insn, fault_insn}.
REQ-004 mret, wfi, ex_mem_stall  in  1 each  pipeline trap-return, wait-for-interrupt, memory-stall flags.
REQ-005 epc, badaddr  in  32  faulting PC and faulting address/instruction.
REQ-006 timer_int, soft_int, ext_int  in  1 each  level-sensitive interrupt sources.
REQ-007 mie_en  in  3  per-source enables {ext, timer, soft}; glob_ie in 1 mstatus.MIE.
REQ-008 mtvec  in  32  trap vector; [1:0] mode (0 direct, 1 vectored), [31:2] base.
REQ-009 insert_pc  out 1  one-cycle redirect strobe; priv_pc out 32 redirect target; intr out 1 redirect is an interrupt.
REQ-010 csr_we  out 1  one-cycle strobe: load mepc/mcause/mtval from mepc_o, mcause_o, mtval_o (out 32 each).
REQ-011 mstatus_trap, mstatus_ret  out 1 each  strobes: trap (MPIE<=MIE, MIE<=0) / return (MIE<=MPIE, MPIE<=1).
REQ-012 mepc_r  in 32  current mepc for mret; wfi_stall  out 1  freeze pipeline while sleeping.

Function
REQ-013 FSM states IDLE, TRAP, RET, SLEEP; each of TRAP/RET lasts exactly one cycle then returns IDLE.
REQ-014 Event evaluated in IDLE only when ex_mem_stall=0; otherwise state holds, no strobes.
REQ-015 Event priority: exception > enabled interrupt (pending & mie_en & glob_ie) > mret > wfi.
REQ-016 Exception priority: insn page > fault_insn > illegal > mal_insn > breakpoint > env > mal_s > mal_l > store page > load page > fault_s > fault_l.
REQ-017 Exception causes: mal_insn 0, fault_insn 1, illegal 2, breakpoint 3, mal_l 4, fault_l 5, mal_s 6, fault_s 7, env 11, insn page 12, load page 13, store page 15; bit31=0.
REQ-018 Interrupt priority ext(11) > soft(3) > timer(7); mcause bit31=1.
REQ-019 IDLE->TRAP on exception/interrupt: registers cause, mepc_o=epc, mtval_o=badaddr (0 for interrupts, env, breakpoint).
REQ-020 In TRAP: insert_pc=1, csr_we=1, mstatus_trap=1, intr=interrupt flag; priv_pc={base,2'b00} for exceptions or direct mode, {base,2'b00}+4*cause[4:0] for vectored interrupts, 32-bit wrap.
REQ-021 IDLE->RET on mret: in RET insert_pc=1, priv_pc=mepc_r, mstatus_ret=1, csr_we=0, intr=0.
REQ-022 IDLE->SLEEP on wfi; wfi_stall=1 in SLEEP; leave when any (pending & mie_en)!=0, ignoring glob_ie.
REQ-023 SLEEP exit: to TRAP same cycle-decision if glob_ie=1 (mepc_o=epc), else IDLE with no redirect.
REQ-024 All strobe outputs 0 outside their state; priv_pc/mepc_o/mcause_o/mtval_o hold last value.
REQ-025 Interrupt dropping while in TRAP does not cancel the trap.

Reset
REQ-026 RST forces IDLE, all outputs 0, next cycle; RST mid-TRAP/RET/SLEEP aborts with no strobe.

Structure
REQ-027 Cause-code enum, state enum, vector-mode constants in machine_mode_types_1_13_pkg.
REQ-028 One sub-module prv_trap_prio: combinational priority encoder returning valid + 5-bit cause.

Verification
REQ-029 illegal_insn=1, epc=0x100, mtvec=0x8000_0001 -> next cycle insert_pc=1, priv_pc=0x8000_0000, mcause_o=2, mepc_o=0x100.
REQ-030 timer_int=1, mie_en=3'b010, glob_ie=1, mtvec=0x8000_0001 -> priv_pc=0x8000_001C, mcause_o=0x8000_0007, intr=1.
REQ-031 fault_l and ext_int and mret same cycle -> exception taken, mcause_o=5, no mstatus_ret.
REQ-032 wfi, glob_ie=0, 5 idle cycles, then soft_int with enable -> wfi_stall 1 for sleep cycles, then IDLE, insert_pc never 1.
REQ-033 mret, mepc_r=0x200 with ex_mem_stall=1 for 3 cycles -> insert_pc only on 1st cycle after stall drops, priv_pc=0x200.
REQ-034 RST asserted during TRAP -> insert_pc and csr_we 0 next cycle, state IDLE.

Source files
------------

// File: rtl/machine_mode_types_1_13_pkg.sv
// Shared types and constants for the machine-mode trap controller:
// FSM states, exception/interrupt cause codes, mtvec modes and the
// trap-vector target helper.
package machine_mode_types_1_13_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_SLEEP = 2'd3
    } trap_state_t;

    typedef enum logic [4:0] {
        CAUSE_MAL_INSN    = 5'd0,
        CAUSE_FAULT_INSN  = 5'd1,
        CAUSE_ILLEGAL     = 5'd2,
        CAUSE_BREAKPOINT  = 5'd3,
        CAUSE_MAL_LOAD    = 5'd4,
        CAUSE_FAULT_LOAD  = 5'd5,
        CAUSE_MAL_STORE   = 5'd6,
        CAUSE_FAULT_STORE = 5'd7,
        CAUSE_ENV         = 5'd11,
        CAUSE_INSN_PAGE   = 5'd12,
        CAUSE_LOAD_PAGE   = 5'd13,
        CAUSE_STORE_PAGE  = 5'd15
    } exc_cause_t;

    typedef enum logic [4:0] {
        INT_SOFT  = 5'd3,
        INT_TIMER = 5'd7,
        INT_EXT   = 5'd11
    } int_cause_t;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    // Bit positions inside the 12-bit exception flag vector.
    localparam int unsigned EXC_FAULT_INSN  = 0;
    localparam int unsigned EXC_MAL_INSN    = 1;
    localparam int unsigned EXC_ILLEGAL     = 2;
    localparam int unsigned EXC_FAULT_LOAD  = 3;
    localparam int unsigned EXC_MAL_LOAD    = 4;
    localparam int unsigned EXC_FAULT_STORE = 5;
    localparam int unsigned EXC_MAL_STORE   = 6;
    localparam int unsigned EXC_BREAKPOINT  = 7;
    localparam int unsigned EXC_ENV         = 8;
    localparam int unsigned EXC_INSN_PAGE   = 9;
    localparam int unsigned EXC_LOAD_PAGE   = 10;
    localparam int unsigned EXC_STORE_PAGE  = 11;

    // Bit positions inside the {ext, timer, soft} interrupt vector.
    localparam int unsigned IRQ_SOFT  = 0;
    localparam int unsigned IRQ_TIMER = 1;
    localparam int unsigned IRQ_EXT   = 2;

    // Redirect target: base for exceptions or direct mode, base + 4*cause
    // for interrupts in vectored mode (wraps at 32 bits).
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic        is_int,
                                                input logic [4:0]  cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        trap_target = base;
        if (is_int && (tvec[1:0] == MTVEC_VECTORED))
            trap_target = base + {25'd0, cause, 2'b00};
    endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: picks the highest-priority
// exception, else the highest-priority (already enabled) interrupt.
module prv_trap_prio
    import machine_mode_types_1_13_pkg::*;
(
    input  logic [11:0] exc,
    input  logic [2:0]  irq,
    output logic        valid,
    output logic        is_int,
    output logic [4:0]  cause,
    output logic        zero_tval
);

    // Fixed-priority selection; zero_tval marks causes that report mtval = 0.
    always_comb begin
        valid     = 1'b0;
        is_int    = 1'b0;
        cause     = '0;
        zero_tval = 1'b0;
        if (exc[EXC_INSN_PAGE]) begin
            valid = 1'b1; cause = CAUSE_INSN_PAGE;
        end else if (exc[EXC_FAULT_INSN]) begin
            valid = 1'b1; cause = CAUSE_FAULT_INSN;
        end else if (exc[EXC_ILLEGAL]) begin
            valid = 1'b1; cause = CAUSE_ILLEGAL;
        end else if (exc[EXC_MAL_INSN]) begin
            valid = 1'b1; cause = CAUSE_MAL_INSN;
        end else if (exc[EXC_BREAKPOINT]) begin
            valid = 1'b1; cause = CAUSE_BREAKPOINT; zero_tval = 1'b1;
        end else if (exc[EXC_ENV]) begin
            valid = 1'b1; cause = CAUSE_ENV; zero_tval = 1'b1;
        end else if (exc[EXC_MAL_STORE]) begin
            valid = 1'b1; cause = CAUSE_MAL_STORE;
        end else if (exc[EXC_MAL_LOAD]) begin
            valid = 1'b1; cause = CAUSE_MAL_LOAD;
        end else if (exc[EXC_STORE_PAGE]) begin
            valid = 1'b1; cause = CAUSE_STORE_PAGE;
        end else if (exc[EXC_LOAD_PAGE]) begin
            valid = 1'b1; cause = CAUSE_LOAD_PAGE;
        end else if (exc[EXC_FAULT_STORE]) begin
            valid = 1'b1; cause = CAUSE_FAULT_STORE;
        end else if (exc[EXC_FAULT_LOAD]) begin
            valid = 1'b1; cause = CAUSE_FAULT_LOAD;
        end else if (irq[IRQ_EXT]) begin
            valid = 1'b1; is_int = 1'b1; cause = INT_EXT; zero_tval = 1'b1;
        end else if (irq[IRQ_SOFT]) begin
            valid = 1'b1; is_int = 1'b1; cause = INT_SOFT; zero_tval = 1'b1;
        end else if (irq[IRQ_TIMER]) begin
            valid = 1'b1; is_int = 1'b1; cause = INT_TIMER; zero_tval = 1'b1;
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap controller: takes exceptions/interrupts, handles mret
// and wfi, and issues one-cycle redirect and CSR-update strobes.
module prv_trap_ctrl
    import machine_mode_types_1_13_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] exc_in,
    input  logic        mret,
    input  logic        wfi,
    input  logic        ex_mem_stall,
    input  logic [31:0] epc,
    input  logic [31:0] badaddr,
    input  logic        timer_int,
    input  logic        soft_int,
    input  logic        ext_int,
    input  logic [2:0]  mie_en,
    input  logic        glob_ie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_r,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic        intr,
    output logic        csr_we,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        mstatus_trap,
    output logic        mstatus_ret,
    output logic        wfi_stall
);

    trap_state_t state;
    logic        intr_q;

    logic [2:0]  irq_pend;
    logic        wake;
    logic [11:0] exc_sel;
    logic        p_valid;
    logic        p_is_int;
    logic [4:0]  p_cause;
    logic        p_zero_tval;

    // Exceptions only count from IDLE; a sleep exit can only be an interrupt.
    assign irq_pend = {ext_int, timer_int, soft_int} & mie_en;
    assign wake     = |irq_pend;
    assign exc_sel  = (state == ST_IDLE) ? exc_in : '0;

    prv_trap_prio u_prio (
        .exc       (exc_sel),
        .irq       (irq_pend & {3{glob_ie}}),
        .valid     (p_valid),
        .is_int    (p_is_int),
        .cause     (p_cause),
        .zero_tval (p_zero_tval)
    );

    // Strobes are decoded from the registered state, so they are glitch-free
    // and drop to zero in the cycle after any reset.
    assign insert_pc    = (state == ST_TRAP) || (state == ST_RET);
    assign csr_we       = (state == ST_TRAP);
    assign mstatus_trap = (state == ST_TRAP);
    assign mstatus_ret  = (state == ST_RET);
    assign intr         = (state == ST_TRAP) && intr_q;
    assign wfi_stall    = (state == ST_SLEEP);

    // FSM plus capture of the trap/return payload on entry to TRAP/RET.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            intr_q   <= 1'b0;
            priv_pc  <= '0;
            mepc_o   <= '0;
            mcause_o <= '0;
            mtval_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!ex_mem_stall) begin
                        if (p_valid) begin
                            state    <= ST_TRAP;
                            intr_q   <= p_is_int;
                            priv_pc  <= trap_target(mtvec, p_is_int, p_cause);
                            mepc_o   <= epc;
                            mcause_o <= {p_is_int, 26'd0, p_cause};
                            mtval_o  <= p_zero_tval ? '0 : badaddr;
                        end else if (mret) begin
                            state   <= ST_RET;
                            intr_q  <= 1'b0;
                            priv_pc <= mepc_r;
                        end else if (wfi) begin
                            state <= ST_SLEEP;
                        end
                    end
                end
                ST_TRAP, ST_RET: state <= ST_IDLE;
                ST_SLEEP: begin
                    // Wake ignores glob_ie; p_valid implies glob_ie here.
                    if (wake) begin
                        if (p_valid) begin
                            state    <= ST_TRAP;
                            intr_q   <= 1'b1;
                            priv_pc  <= trap_target(mtvec, 1'b1, p_cause);
                            mepc_o   <= epc;
                            mcause_o <= {1'b1, 26'd0, p_cause};
                            mtval_o  <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Scoreboard bench for prv_trap_ctrl: a transaction-level reference model
// predicts each redirect when stimulus is issued; a monitor checks them.
module tb_prv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] exc_in = '0;
    logic        mret = 1'b0, wfi = 1'b0, ex_mem_stall = 1'b0;
    logic [31:0] epc = '0, badaddr = '0, mtvec = '0, mepc_r = '0;
    logic        timer_int = 1'b0, soft_int = 1'b0, ext_int = 1'b0;
    logic [2:0]  mie_en = '0;
    logic        glob_ie = 1'b0;
    logic        insert_pc, intr, csr_we, mstatus_trap, mstatus_ret, wfi_stall;
    logic [31:0] priv_pc, mepc_o, mcause_o, mtval_o;

    prv_trap_ctrl dut (
        .CLK(CLK), .RST(RST), .exc_in(exc_in), .mret(mret), .wfi(wfi),
        .ex_mem_stall(ex_mem_stall), .epc(epc), .badaddr(badaddr),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mie_en(mie_en), .glob_ie(glob_ie), .mtvec(mtvec), .mepc_r(mepc_r),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr), .csr_we(csr_we),
        .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
        .mstatus_trap(mstatus_trap), .mstatus_ret(mstatus_ret), .wfi_stall(wfi_stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_ret;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        bit          intr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   m_busy = 1'b0;   // controller is presenting a redirect this cycle
    bit   m_sleep = 1'b0;  // controller is asleep

    // Exception priority list (flag bit, cause code), highest first.
    int EXC_BIT[12]  = '{9, 0, 2, 1, 7, 8, 6, 4, 11, 10, 5, 3};
    int EXC_CODE[12] = '{12, 1, 2, 0, 3, 11, 6, 4, 15, 13, 7, 5};
    // Interrupt priority list over {ext, timer, soft}: ext, soft, timer.
    int INT_BIT[3]   = '{2, 0, 1};
    int INT_CODE[3]  = '{11, 3, 7};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(logic [31:0] tv, bit is_int, int code);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        if (is_int && tv[1:0] == 2'd1) return base + 32'(4 * code);
        return base;
    endfunction

    task automatic push_int(logic [2:0] src);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (src[INT_BIT[k]]) begin
                e.is_ret = 0; e.intr = 1;
                e.cause  = 32'h8000_0000 | 32'(INT_CODE[k]);
                e.pc     = target(mtvec, 1, INT_CODE[k]);
                e.mepc   = epc; e.mtval = '0;
                q.push_back(e);
                m_busy = 1;
                return;
            end
        end
    endtask

    // Predicts what the controller does at the coming rising edge.
    task automatic model_step();
        exp_t       e;
        logic [2:0] src;
        src = {ext_int, timer_int, soft_int} & mie_en;
        if (RST) begin m_busy = 0; m_sleep = 0; return; end
        if (m_busy) begin m_busy = 0; return; end
        if (m_sleep) begin
            if (src != 0) begin
                m_sleep = 0;
                if (glob_ie) push_int(src);
            end
            return;
        end
        if (ex_mem_stall) return;
        for (int k = 0; k < 12; k++) begin
            if (exc_in[EXC_BIT[k]]) begin
                e.is_ret = 0; e.intr = 0;
                e.cause  = 32'(EXC_CODE[k]);
                e.pc     = target(mtvec, 0, EXC_CODE[k]);
                e.mepc   = epc;
                e.mtval  = (EXC_CODE[k] == 3 || EXC_CODE[k] == 11) ? '0 : badaddr;
                q.push_back(e);
                m_busy = 1;
                return;
            end
        end
        if (glob_ie && src != 0) begin push_int(src); return; end
        if (mret) begin
            e.is_ret = 1; e.intr = 0; e.pc = mepc_r;
            e.cause = '0; e.mepc = '0; e.mtval = '0;
            q.push_back(e);
            m_busy = 1;
        end else if (wfi) begin
            m_sleep = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic quiet();
        exc_in = '0; mret = 0; wfi = 0; ex_mem_stall = 0;
        timer_int = 0; soft_int = 0; ext_int = 0;
    endtask

    // Monitor: pops an expected redirect whenever the DUT shows a strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                check("wfi_stall", {31'd0, wfi_stall}, {31'd0, m_sleep});
                if (insert_pc || csr_we || mstatus_trap || mstatus_ret || intr) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: got insert_pc=%0b csr_we=%0b ret=%0b expected none at %0t",
                                 insert_pc, csr_we, mstatus_ret, $time);
                    end else begin
                        e = q.pop_front();
                        check("insert_pc", {31'd0, insert_pc}, 32'd1);
                        check("csr_we", {31'd0, csr_we}, {31'd0, !e.is_ret});
                        check("mstatus_trap", {31'd0, mstatus_trap}, {31'd0, !e.is_ret});
                        check("mstatus_ret", {31'd0, mstatus_ret}, {31'd0, e.is_ret});
                        check("intr", {31'd0, intr}, {31'd0, e.intr});
                        check("priv_pc", priv_pc, e.pc);
                        if (!e.is_ret) begin
                            check("mcause_o", mcause_o, e.cause);
                            check("mepc_o", mepc_o, e.mepc);
                            check("mtval_o", mtval_o, e.mtval);
                        end
                    end
                end
            end
        end
    end

    initial begin
        @(negedge CLK);
        RST = 1;
        repeat (3) tick();
        RST = 0;
        check("reset_insert_pc", {31'd0, insert_pc}, 32'd0);
        check("reset_csr_we", {31'd0, csr_we}, 32'd0);
        check("reset_priv_pc", priv_pc, 32'd0);
        check("reset_mcause", mcause_o, 32'd0);
        check("reset_wfi_stall", {31'd0, wfi_stall}, 32'd0);
        mon_en = 1;

        // Illegal instruction, vectored mtvec: exceptions still go to base.
        quiet(); exc_in = 12'h004; epc = 32'h100; badaddr = 32'hDEAD_BEEF;
        mtvec = 32'h8000_0001;
        tick(); quiet();
        check("illegal_pc", priv_pc, 32'h8000_0000);
        check("illegal_cause", mcause_o, 32'd2);
        check("illegal_mepc", mepc_o, 32'h100);
        tick();

        // Vectored timer interrupt; source drops during TRAP.
        timer_int = 1; mie_en = 3'b010; glob_ie = 1; mtvec = 32'h8000_0001;
        tick(); quiet();
        check("timer_pc", priv_pc, 32'h8000_001C);
        check("timer_cause", mcause_o, 32'h8000_0007);
        check("timer_intr", {31'd0, intr}, 32'd1);
        tick();

        // Exception beats interrupt and mret.
        exc_in = 12'h008; ext_int = 1; mie_en = 3'b100; glob_ie = 1; mret = 1;
        tick(); quiet();
        check("prio_cause", mcause_o, 32'd5);
        check("prio_no_ret", {31'd0, mstatus_ret}, 32'd0);
        tick();

        // wfi with interrupts globally disabled: wake without redirect.
        glob_ie = 0; mie_en = 3'b001; wfi = 1;
        tick(); wfi = 0;
        check("sleep_enter", {31'd0, wfi_stall}, 32'd1);
        repeat (5) tick();
        check("sleep_hold", {31'd0, wfi_stall}, 32'd1);
        soft_int = 1;
        tick();
        check("sleep_exit", {31'd0, wfi_stall}, 32'd0);
        check("sleep_no_redirect", {31'd0, insert_pc}, 32'd0);
        soft_int = 0;
        tick();

        // mret held off by ex_mem_stall.
        mret = 1; mepc_r = 32'h200; ex_mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_redirect", {31'd0, insert_pc}, 32'd0);
        end
        ex_mem_stall = 0;
        tick(); mret = 0;
        check("ret_insert_pc", {31'd0, insert_pc}, 32'd1);
        check("ret_pc", priv_pc, 32'h200);
        tick();
        check("ret_one_cycle", {31'd0, insert_pc}, 32'd0);

        // Reset during TRAP aborts the strobes.
        exc_in = 12'h001;
        tick(); quiet();
        check("pre_reset_trap", {31'd0, csr_we}, 32'd1);
        RST = 1;
        tick(); RST = 0;
        check("rst_insert_pc", {31'd0, insert_pc}, 32'd0);
        check("rst_csr_we", {31'd0, csr_we}, 32'd0);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            RST          = ($urandom_range(0, 59) == 0);
            exc_in       = ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'd0;
            timer_int    = ($urandom_range(0, 5) == 0);
            soft_int     = ($urandom_range(0, 5) == 0);
            ext_int      = ($urandom_range(0, 5) == 0);
            mie_en       = 3'($urandom);
            glob_ie      = ($urandom_range(0, 9) < 7);
            mret         = ($urandom_range(0, 4) == 0);
            wfi          = ($urandom_range(0, 5) == 0);
            ex_mem_stall = ($urandom_range(0, 3) == 0);
            epc          = $urandom;
            badaddr      = $urandom;
            mepc_r       = $urandom;
            mtvec        = $urandom;
            tick();
        end
        RST = 0; quiet();
        repeat (3) tick();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
